bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised N-digit BCD up/down counter with an internal tick prescaler, synchronous load, wrap flag and per-digit 7-segment decode. It is the successor to the fixed 3-digit, 0–999 seconds counter. It replaces the ripple-clocked digit chain with a single-clock synchronous cascade, and adds direction, enable, preset load and leading-zero blanking. It sits between the board clock/switches and the HEX displays.

## Interface
Parameters:
- DIGITS, 3: number of BCD digits; count range 0 .. 10^DIGITS−1.
- TICK_DIV, 50000000: Clk50 cycles per count step; must be ≥1.
- DIV_W, 26: prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.
- BLANK_LZ, 0: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- Clk50  in  1  system clock; all state changes on its rising edge.
- KEY  in  1  reset, asynchronous, active-low.
- EN  in  1  1 = step on tick; 0 = hold the count; the prescaler keeps running.
- UP  in  1  1 = count up, 0 = count down.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  4*DIGITS  BCD preset; digit i is bits [4i+3:4i].
- BCD  out  4*DIGITS  current count, BCD, digit 0 = LSD.
- HEX  out  7*DIGITS  active-low segments; digit i is bits [7i+6:7i]; bit0 = a … bit6 = g.
- TICK  out  1  high for the one cycle when the prescaler = TICK_DIV−1.
- WRAP  out  1  registered one-cycle pulse when the count wraps.

## Operation
- Prescaler: a DIV_W-bit counter runs 0 → TICK_DIV−1 → 0 continuously, independent of EN and UP. LOAD clears it to 0.
- TICK is combinational and equals (prescaler == TICK_DIV−1). With TICK_DIV=1, TICK is constantly 1.
- Step condition: TICK & EN & ~LOAD.
- Up step: the LSD increments. A digit at 9 becomes 0 and carries into the next digit in the same cycle (synchronous cascade, no derived clocks).
  - All digits at 9 → all digits at 0, and WRAP=1 next cycle.
- Down step: the LSD decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 → all digits at 9, and WRAP=1 next cycle.
- LOAD has priority over a step. BCD <= LOAD_VAL, except that any digit >9 loads as 0. WRAP=0 and the prescaler goes to 0.
- UP or EN changes take effect at the next step. There is no glitch and no extra step.
- Decode: HEX is combinational from the registered BCD, using standard active-low patterns.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (listed g..a).
- BLANK_LZ=1: digit i>0 shows 1111111 when it and every higher digit are 0.

## Timing
- KEY low, asynchronously: prescaler=0, BCD=0, WRAP=0.
  - TICK=0 unless TICK_DIV=1.
  - HEX shows all digits "0"; with BLANK_LZ=1, digit 0 shows "0" and the others are blank.
- After KEY deasserts, the first step occurs on rising edge number TICK_DIV. Each later step occurs every TICK_DIV cycles.
- Step and load latency: BCD updates on the edge where the condition is sampled. HEX follows in the same cycle, combinationally.
- WRAP is high for exactly the cycle after the wrapping edge, concurrent with the new BCD value.
- LOAD and a tick in the same cycle: the load wins, no step occurs, and the prescaler restarts at 0. The next step comes TICK_DIV cycles later.
- LOAD held for several cycles: BCD tracks LOAD_VAL every cycle and the prescaler stays at 0.
- If KEY asserts mid-count, everything clears immediately, regardless of Clk50.

## Test plan
Bench settings: DIGITS=3, TICK_DIV=4, BLANK_LZ=0 unless noted.
- Reset: hold KEY=0 with random inputs. Required: BCD=000, WRAP=0, HEX=1000000 ×3. Release KEY with EN=1, UP=1. Required: BCD=001 after 4 edges, and a step every 4 edges after that.
- Up cascade and wrap: LOAD 998, EN=1, UP=1. Required: sequence 999 → 000 with WRAP=1 for one cycle at 000, and 099 → 100 as a single-step transition.
- Down wrap: LOAD 001, UP=0. Required: 000 → 999 with a one-cycle WRAP. Also LOAD 100 → 099.
- Enable and priority: EN=0 for 20 cycles. Required: BCD holds while TICK keeps pulsing every 4 cycles.
  - Then assert LOAD=1 with LOAD_VAL=0x5A7 in the same cycle as TICK. Required: BCD=507 (the digit >9 is zeroed), no step, and the next step 4 cycles later.
- Blanking: BLANK_LZ=1, LOAD 005. Required: HEX2 and HEX1 = 1111111, HEX0 = 0010010. LOAD 105 shows all digits, with the middle digit "0".
- Async reset mid-count: drop KEY between Clk50 edges while at 456. Required: BCD=000 and prescaler=0 before the next edge.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with tick prescaler, synchronous load,
// wrap pulse and per-digit active-low 7-segment decode.
module bcd_updown_counter #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26,
  parameter int BLANK_LZ = 0
) (
  input  logic                Clk50,
  input  logic                KEY,
  input  logic                EN,
  input  logic                UP,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] LOAD_VAL,
  output logic [4*DIGITS-1:0] BCD,
  output logic [7*DIGITS-1:0] HEX,
  output logic                TICK,
  output logic                WRAP
);

  localparam int CW = 4 * DIGITS;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             step;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign TICK = (div_q == DIV_MAX);
  assign step = TICK & EN & ~LOAD;

  always_comb begin : next_state
    logic       cy;
    logic [3:0] dig;
    logic [3:0] ld;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    div_d  = TICK ? '0 : div_q + DIV_W'(1);
    cy     = step;
    dig    = '0;
    ld     = '0;
    // carry/borrow ripples through all digits in one cycle
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (cy) begin
        if (UP)
          cnt_d[4*i +: 4] =
            (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else
          cnt_d[4*i +: 4] =
            (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      cy = cy & (UP ? (dig == 4'd9)
                    : (dig == 4'd0));
    end
    unique case (1'b1)
      LOAD: begin
        div_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
          ld = LOAD_VAL[4*i +: 4];
          cnt_d[4*i +: 4] =
            (ld > 4'd9) ? 4'd0 : ld;
        end
      end
      step:    wrap_d = cy;
      default: wrap_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk50 or negedge KEY) begin
    if (!KEY) begin
      div_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin : decode
    logic z;
    z   = 1'b1;
    HEX = '1;
    // z: this digit and all above it are zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (cnt_q[4*i +: 4] == 4'd0);
      if (BLANK_LZ != 0 && i > 0 && z)
        HEX[7*i +: 7] = 7'b1111111;
      else
        HEX[7*i +: 7] = seg7(cnt_q[4*i +: 4]);
    end
  end

  assign BCD  = cnt_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed steps plus random
// traffic against an integer-valued reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        key, en, up, load;
  logic [11:0] lval;
  logic [11:0] bcd, bcd_b;
  logic [20:0] hex, hex_b;
  logic        tick, tick_b, wrap, wrap_b;

  int total = 0;
  int bad   = 0;
  int mv, mph, nt;
  bit mwrap;
  logic [11:0] held;

  int pw [3] = '{1, 10, 100};
  logic [6:0] seg [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  bcd_updown_counter #(
    .DIGITS(3), .TICK_DIV(4), .DIV_W(3), .BLANK_LZ(0)
  ) dut (
    .Clk50(clk), .KEY(key), .EN(en), .UP(up),
    .LOAD(load), .LOAD_VAL(lval), .BCD(bcd),
    .HEX(hex), .TICK(tick), .WRAP(wrap));

  bcd_updown_counter #(
    .DIGITS(3), .TICK_DIV(4), .DIV_W(3), .BLANK_LZ(1)
  ) dut_b (
    .Clk50(clk), .KEY(key), .EN(en), .UP(up),
    .LOAD(load), .LOAD_VAL(lval), .BCD(bcd_b),
    .HEX(hex_b), .TICK(tick_b), .WRAP(wrap_b));

  function automatic int ld_val(logic [11:0] x);
    int r = 0;
    int d;
    for (int i = 0; i < 3; i++) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) d = 0;
      r += d * pw[i];
    end
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = 4'((v / pw[i]) % 10);
    return r;
  endfunction

  function automatic logic [20:0] exp_hex(int v, bit blank);
    logic [20:0] r;
    for (int i = 0; i < 3; i++) begin
      if (blank && i > 0 && v < pw[i])
        r[7*i +: 7] = 7'b1111111;
      else
        r[7*i +: 7] = seg[(v / pw[i]) % 10];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("bcd", 32'(bcd), 32'(to_bcd(mv)));
    check("wrap", 32'(wrap), 32'(mwrap));
    check("tick", 32'(tick), 32'(mph == 3));
    check("hex", 32'(hex), 32'(exp_hex(mv, 1'b0)));
    check("bcd_b", 32'(bcd_b), 32'(to_bcd(mv)));
    check("hex_b", 32'(hex_b), 32'(exp_hex(mv, 1'b1)));
  endtask

  task automatic model_reset();
    mv = 0;
    mph = 0;
    mwrap = 1'b0;
  endtask

  // one clock: model advances with the edge, outputs checked 1ns later
  task automatic cyc(int n);
    bit t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!key) begin
        model_reset();
      end else if (load) begin
        mv = ld_val(lval);
        mph = 0;
        mwrap = 1'b0;
      end else begin
        t = (mph == 3);
        mwrap = 1'b0;
        if (t && en) begin
          if (up) begin
            mwrap = (mv == 999);
            mv = (mv + 1) % 1000;
          end else begin
            mwrap = (mv == 0);
            mv = (mv + 999) % 1000;
          end
        end
        mph = t ? 0 : mph + 1;
      end
      #1;
      check_model();
    end
  endtask

  task automatic do_load(logic [11:0] v);
    load = 1'b1;
    lval = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    key = 1'b1;
    en = 1'b0;
    up = 1'b1;
    load = 1'b0;
    lval = '0;
    model_reset();
    #1 key = 1'b0;
    #1;
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_hex", 32'(hex), 32'h1020408 >> 0 == 0 ?
          32'h0 : 32'(exp_hex(0, 1'b0)));
    // reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      en = 1'($urandom);
      up = 1'($urandom);
      load = 1'($urandom);
      lval = 12'($urandom);
      cyc(1);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_hex_lit", 32'(hex),
            32'({7'b1000000, 7'b1000000, 7'b1000000}));
    end
    en = 1'b1;
    up = 1'b1;
    load = 1'b0;
    key = 1'b1;
    cyc(3);
    check("pre_first_step", 32'(bcd), 32'h000);
    cyc(1);
    check("first_step", 32'(bcd), 32'h001);
    cyc(4);
    check("second_step", 32'(bcd), 32'h002);

    // up cascade and wrap
    do_load(12'h998);
    cyc(4);
    check("up_999", 32'(bcd), 32'h999);
    cyc(4);
    check("up_wrap_bcd", 32'(bcd), 32'h000);
    check("up_wrap_flag", 32'(wrap), 32'h1);
    cyc(1);
    check("up_wrap_clear", 32'(wrap), 32'h0);
    do_load(12'h099);
    cyc(4);
    check("up_099_100", 32'(bcd), 32'h100);

    // down wrap and borrow
    up = 1'b0;
    do_load(12'h001);
    cyc(4);
    check("dn_000", 32'(bcd), 32'h000);
    cyc(4);
    check("dn_wrap_bcd", 32'(bcd), 32'h999);
    check("dn_wrap_flag", 32'(wrap), 32'h1);
    cyc(1);
    check("dn_wrap_clear", 32'(wrap), 32'h0);
    do_load(12'h100);
    cyc(4);
    check("dn_100_099", 32'(bcd), 32'h099);

    // hold with EN=0, prescaler keeps running
    en = 1'b0;
    held = bcd;
    nt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (tick) nt++;
    end
    check("hold_bcd", 32'(bcd), 32'(held));
    check("hold_ticks", 32'(nt), 32'd5);

    // load coincident with tick wins
    for (int k = 0; k < 4 && mph != 3; k++) cyc(1);
    check("tick_aligned", 32'(tick), 32'h1);
    en = 1'b1;
    up = 1'b1;
    do_load(12'h5A7);
    check("load_prio", 32'(bcd), 32'h507);
    cyc(3);
    check("load_no_step", 32'(bcd), 32'h507);
    cyc(1);
    check("load_next_step", 32'(bcd), 32'h508);

    // leading-zero blanking
    en = 1'b0;
    do_load(12'h005);
    check("blank_005", 32'(hex_b),
          32'({7'b1111111, 7'b1111111, 7'b0010010}));
    do_load(12'h105);
    check("blank_105", 32'(hex_b),
          32'({7'b1111001, 7'b1000000, 7'b0010010}));

    // random traffic
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) up = ~up;
      load = ($urandom_range(0, 15) == 0);
      lval = 12'($urandom);
      cyc(1);
    end
    load = 1'b0;

    // async reset between edges mid-count
    en = 1'b1;
    up = 1'b1;
    do_load(12'h456);
    cyc(2);
    #2 key = 1'b0;
    #1;
    model_reset();
    check("async_bcd", 32'(bcd), 32'h000);
    check("async_wrap", 32'(wrap), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    #1 key = 1'b1;
    cyc(3);
    check("async_pre_step", 32'(bcd), 32'h000);
    cyc(1);
    check("async_first_step", 32'(bcd), 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
